imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Write-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake, typically from a UART receiver or debug bridge, and assembles the bytes into little-endian 32-bit words. It then drives the instruction memory write port with sequential word addresses starting at 0. While a load is in progress it holds the CPU, and it reports completion, an overflow error and a running checksum.

Parameters:
IMEM_WORDS, 4096, instruction memory depth in 32-bit words
ADDR_W, 12, word-index width; must equal clog2(IMEM_WORDS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to begin a load; ignored while busy
len_words  in  ADDR_W+1  number of words to load; latched on an accepted start
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  loader can accept in_data this cycle
mem_we  out  1  write strobe to instruction memory, 1 cycle per word
mem_addr  out  32  byte address of the word being written; word_idx<<2, bits [1:0]=0
mem_wdata  out  32  assembled word
busy  out  1  load in progress
cpu_hold  out  1  stall/reset request to core; equals busy
done  out  1  high from load completion until the next accepted start or reset
err_overflow  out  1  the last start requested len_words > IMEM_WORDS
checksum  out  32  modulo-2^32 sum of all words written in the current load

Behaviour:
- Reset values: all outputs 0, state IDLE, word_idx 0, byte_cnt 0, assembly register 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: in_ready=0. On start:
  - clear done, err_overflow and checksum; latch len_words into len_r.
  - if len_words > IMEM_WORDS: set err_overflow, go to DONE with no writes.
  - else if len_words == 0: go to DONE.
  - else go to RECV with word_idx=0 and byte_cnt=0.
- RECV: in_ready=1 and busy=1.
  - A byte transfers only on a cycle with in_valid && in_ready.
  - The byte at byte_cnt=k lands in asm[8k+7:8k], so the first byte goes to [7:0].
  - byte_cnt increments by 1 on each transfer.
  - On the 4th transfer (byte_cnt==3), go to WRITE and reset byte_cnt to 0.
  - in_valid low means no change; stalls of any length are allowed.
- WRITE: exactly one cycle.
  - in_ready=0, mem_we=1, mem_addr={word_idx,2'b00} zero-extended to 32 bits, mem_wdata=asm.
  - checksum <= checksum + asm.
  - If word_idx+1 == len_r, go to DONE; else word_idx++ and go to RECV.
- Throughput: 5 cycles per word at the minimum (4 accept cycles plus 1 write cycle).
- DONE: done=1, busy=0, in_ready=0. A new start is handled exactly as in IDLE, so DONE and IDLE differ only by the done flag.
- Outside WRITE: mem_we=0, and mem_addr/mem_wdata hold their last values.
- start while in RECV or WRITE is ignored; len_r is unchanged.
- Bytes offered while in_ready=0 are not consumed; the source must hold them.
- Reset mid-load: returns to IDLE next cycle, all outputs go to 0, the partial word is discarded. Words already written stay in memory; there is no rollback.
- len_words == IMEM_WORDS is legal. The last address is (IMEM_WORDS-1)<<2; word_idx must not wrap before the compare.
- Arithmetic: the len compare is done at ADDR_W+1 bits. checksum wraps mod 2^32.

Decomposition:
- Shared package: state encoding enum (IDLE/RECV/WRITE/DONE), NOP constant 32'h00000013 for the bench fill check, IMEM_WORDS default.
- One natural sub-module: byte_packer (byte_cnt, asm register, word_ready pulse). The FSM and counters stay in the top module.

Test Plan:
1. Reset then idle, no start -> in_ready=0, busy=0, done=0, mem_we=0, checksum=0 for 20 cycles.
2. start, len_words=2, bytes 13 00 00 00 B7 10 00 00, in_valid held high ->
   - mem_we at addr 0 with data 0x00000013;
   - then mem_we at addr 4 with data 0x000010B7;
   - done=1, checksum=0x000010CA, cpu_hold high only between start and done.
3. Same load with in_valid toggling randomly, and start pulsed mid-load -> identical writes and checksum; start ignored.
4. start with len_words=4097 -> err_overflow=1, done=1, zero mem_we pulses. start with len_words=0 -> done=1, err_overflow=0, zero writes.
5. len_words=4096 with byte pattern = word index -> last write at mem_addr 0x3FFC, exactly 4096 mem_we pulses, no address wrap.
6. rst asserted after 6 bytes of a 3-word load -> word 0 written; next cycle all outputs 0, state IDLE. A fresh load of 1 word then writes addr 0 correctly with no stale bytes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM state encoding, default memory depth and the NOP fill word
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam int IMEM_WORDS_DEF = 4096;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: packs bytes little-endian into a word; in clk/rst/clr/en/din, out word/word_ready
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready
);
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  always_comb begin
    byte_cnt_d = clr ? 2'd0 : en ? byte_cnt_q + 2'd1 : byte_cnt_q;
    asm_d = asm_q;
    if (en) asm_d[8*byte_cnt_q +: 8] = din;
    word_ready = en && byte_cnt_q == 2'd3;
    word = asm_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      asm_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q <= asm_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte stream -> imem word writes; in start/len_words/in_valid/in_data, out in_ready/mem_*/busy/cpu_hold/done/err_overflow/checksum
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_overflow,
  output logic [31:0]       checksum
);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(IMEM_WORDS);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d, addr_hold_q, addr_hold_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                err_q, err_d;
  logic [31:0]         cks_q, cks_d, wdata_hold_q, wdata_hold_d;
  logic                accept, word_ready;
  logic [31:0]         word;
  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .en         (in_valid && in_ready),
    .din        (in_data),
    .word       (word),
    .word_ready (word_ready)
  );
  always_comb begin
    state_d = state_q;
    word_idx_d = word_idx_q;
    len_d = len_q;
    err_d = err_q;
    cks_d = cks_q;
    addr_hold_d = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    accept = start && (state_q == IDLE || state_q == DONE);
    case (state_q)
      RECV: state_d = word_ready ? WRITE : RECV;
      WRITE: begin
        cks_d = cks_q + word;
        addr_hold_d = word_idx_q;
        wdata_hold_d = word;
        // compare one bit wider so a full-depth load ends without word_idx wrapping
        if ({1'b0, word_idx_q} + (ADDR_W+1)'(1) == len_q) state_d = DONE;
        else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
      default: if (accept) begin
        len_d = len_words;
        err_d = len_words > MAX_LEN;
        cks_d = '0;
        word_idx_d = '0;
        state_d = (len_words > MAX_LEN || len_words == '0) ? DONE : RECV;
      end
    endcase
    in_ready = state_q == RECV;
    mem_we = state_q == WRITE;
    busy = state_q == RECV || state_q == WRITE;
    cpu_hold = busy;
    done = state_q == DONE;
    err_overflow = err_q;
    checksum = cks_q;
    mem_addr = 32'({mem_we ? word_idx_q : addr_hold_q, 2'b00});
    mem_wdata = mem_we ? word : wdata_hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_idx_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
      cks_q <= '0;
      addr_hold_q <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q <= state_d;
      word_idx_q <= word_idx_d;
      len_q <= len_d;
      err_q <= err_d;
      cks_q <= cks_d;
      addr_hold_q <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  import imem_loader_pkg::*;
  logic        clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [12:0] len_words = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, busy, cpu_hold, done, err_overflow;
  logic [31:0] mem_addr, mem_wdata, checksum;
  int tests = 0, fails = 0, we_cnt = 0, base = 0, zc = 0;
  logic [31:0] wa [16384];
  logic [31:0] wd [16384];
  logic [31:0] mem [4096];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done),
    .err_overflow(err_overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) begin
    wa[we_cnt] = mem_addr;
    wd[we_cnt] = mem_wdata;
    mem[mem_addr[13:2]] = mem_wdata;
    we_cnt++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1;
    in_data = b;
    while (!in_ready && t < 50) begin
      tick;
      t++;
    end
    if (t >= 50) check("byte_timeout", 32'(t), 0);
    tick;
    in_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 0; k < 4; k++) begin
      if (rnd) repeat ($urandom_range(0, 2)) tick;
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic do_start(input int n);
    start = 1;
    len_words = 13'(n);
    tick;
    start = 0;
  endtask

  task automatic wait_done(input int max);
    int t = 0;
    while (!done && t < max) begin
      tick;
      t++;
    end
    check("done_wait", done, 1);
  endtask

  task automatic check_two_word_load(input string p);
    check({p, "_count"}, we_cnt - base, 2);
    check({p, "_addr0"}, wa[base], 0);
    check({p, "_data0"}, wd[base], 32'h0000_0013);
    check({p, "_addr1"}, wa[base+1], 4);
    check({p, "_data1"}, wd[base+1], 32'h0000_10B7);
    check({p, "_cks"}, checksum, 32'h0000_10CA);
    check({p, "_hold"}, cpu_hold, 0);
    check({p, "_err"}, err_overflow, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = NOP;
    tick;
    tick;
    rst = 0;
    // 1: idle without start
    for (int i = 0; i < 20; i++) begin
      tick;
      check("idle_ctrl", {26'd0, in_ready, busy, done, mem_we, cpu_hold, err_overflow}, 0);
      check("idle_cks", checksum, 0);
    end
    // 2: two-word load, continuous stream
    base = we_cnt;
    do_start(2);
    check("t2_busy", {busy, cpu_hold, in_ready, done}, 4'b1110);
    send_word(32'h0000_0013, 0);
    send_word(32'h0000_10B7, 0);
    wait_done(10);
    check_two_word_load("t2");
    check("t2_addr_hold", mem_addr, 4);
    check("t2_wdata_hold", mem_wdata, 32'h0000_10B7);
    check("t2_fill", mem[2], NOP);
    // 3: same load with stalls and an ignored start mid-load
    base = we_cnt;
    do_start(2);
    check("t3_done_clr", done, 0);
    send_word(32'h0000_0013, 1);
    send_byte(8'hB7);
    do_start(5);
    check("t3_start_ign", {busy, done}, 2'b10);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done(20);
    check_two_word_load("t3");
    // 4: overflow and zero length
    base = we_cnt;
    do_start(4097);
    check("t4_ovf", {done, err_overflow, busy}, 3'b110);
    check("t4_ovf_cks", checksum, 0);
    repeat (3) tick;
    check("t4_ovf_nowr", we_cnt - base, 0);
    do_start(0);
    check("t4_zero", {done, err_overflow, busy}, 3'b100);
    repeat (3) tick;
    check("t4_zero_nowr", we_cnt - base, 0);
    // 5: full-depth load, word i carries value i
    base = we_cnt;
    do_start(4096);
    for (int i = 0; i < 4096; i++) send_word(32'(i), 0);
    wait_done(10);
    check("t5_count", we_cnt - base, 4096);
    check("t5_last_addr", wa[base+4095], 32'h0000_3FFC);
    check("t5_last_data", wd[base+4095], 32'd4095);
    check("t5_first_addr", wa[base], 0);
    for (int i = base; i < we_cnt; i++) if (wa[i] == 0) zc++;
    check("t5_addr0_once", zc, 1);
    check("t5_mem_last", mem[4095], 32'd4095);
    check("t5_cks", checksum, 32'h007F_F800);
    // 6: reset mid-load, then a clean one-word load
    base = we_cnt;
    do_start(3);
    send_word(32'hAABB_CCDD, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    check("t6_w0_count", we_cnt - base, 1);
    check("t6_w0_data", wd[base], 32'hAABB_CCDD);
    rst = 1;
    tick;
    check("t6_rst_ctrl", {26'd0, in_ready, busy, done, mem_we, cpu_hold, err_overflow}, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_wdata", mem_wdata, 0);
    check("t6_rst_cks", checksum, 0);
    rst = 0;
    tick;
    base = we_cnt;
    do_start(1);
    send_word(32'h1234_5678, 0);
    wait_done(10);
    check("t6_count", we_cnt - base, 1);
    check("t6_addr", wa[base], 0);
    check("t6_data", wd[base], 32'h1234_5678);
    check("t6_cks", checksum, 32'h1234_5678);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
